// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arithmetic/link results plus an optional
// iterative restoring divider for DIV/DIVU, compiled in only when EX_DIV_EN is defined.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_aluop,
    input  logic [2:0]  ex_alusel,
    input  logic [31:0] ex_reg1,
    input  logic [31:0] ex_reg2,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_link_address,
    input  logic        ex_is_in_delayslot,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH       = 3'b100;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

    logic        is_div;
    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] arith_res;

    assign is_div = (ex_aluop == EXE_DIV_OP) || (ex_aluop == EXE_DIVU_OP);
    assign wd_o   = ex_wd;
    // Divides write HI/LO, never a GPR.
    assign wreg_o = ex_wreg & ~is_div;

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        case (ex_aluop)
            EXE_OR_OP:   logic_res = ex_reg1 | ex_reg2;
            EXE_AND_OP:  logic_res = ex_reg1 & ex_reg2;
            EXE_XOR_OP:  logic_res = ex_reg1 ^ ex_reg2;
            EXE_NOR_OP:  logic_res = ~(ex_reg1 | ex_reg2);
            default:     logic_res = '0;
        endcase
        case (ex_aluop)
            EXE_SLL_OP:  shift_res = ex_reg2 << ex_reg1[4:0];
            EXE_SRL_OP:  shift_res = ex_reg2 >> ex_reg1[4:0];
            EXE_SRA_OP:  shift_res = $unsigned($signed(ex_reg2) >>> ex_reg1[4:0]);
            default:     shift_res = '0;
        endcase
        case (ex_aluop)
            EXE_ADDU_OP: arith_res = ex_reg1 + ex_reg2;
            EXE_SUBU_OP: arith_res = ex_reg1 - ex_reg2;
            EXE_SLT_OP:  arith_res = {31'b0, $signed(ex_reg1) < $signed(ex_reg2)};
            EXE_SLTU_OP: arith_res = {31'b0, ex_reg1 < ex_reg2};
            default:     arith_res = '0;
        endcase
        case (ex_alusel)
            EXE_RES_LOGIC:       wdata_o = logic_res;
            EXE_RES_SHIFT:       wdata_o = shift_res;
            EXE_RES_ARITH:       wdata_o = arith_res;
            EXE_RES_JUMP_BRANCH: wdata_o = ex_link_address;
            default:             wdata_o = '0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} div_state_t;

    div_state_t  state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] dividend_reg, dividend_next;
    logic [31:0] divisor_reg, divisor_next;
    logic [31:0] remainder_reg, remainder_next;
    logic        neg_q_reg, neg_q_next;
    logic        neg_r_reg, neg_r_next;

    logic        is_signed;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        unused_ok;

    assign unused_ok = ex_is_in_delayslot;
    assign is_signed = (ex_aluop == EXE_DIV_OP);
    assign mag1      = (is_signed && ex_reg1[31]) ? (~ex_reg1 + 32'd1) : ex_reg1;
    assign mag2      = (is_signed && ex_reg2[31]) ? (~ex_reg2 + 32'd1) : ex_reg2;
    // Dividend register shifts out its MSB into the partial remainder and takes the
    // new quotient bit at its LSB, so it holds the quotient after 32 steps.
    assign rem_shift = {remainder_reg, dividend_reg[31]};
    assign diff      = rem_shift - {1'b0, divisor_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            remainder_reg <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
            remainder_reg <= remainder_next;
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        dividend_next  = dividend_reg;
        divisor_next   = divisor_reg;
        remainder_next = remainder_reg;
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
        stallreq_o     = 1'b0;
        whilo_o        = 1'b0;
        hi_o           = '0;
        lo_o           = '0;
        if (rst || annul_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_div) begin
                        stallreq_o     = 1'b1;
                        cnt_next       = '0;
                        dividend_next  = mag1;
                        divisor_next   = mag2;
                        remainder_next = '0;
                        neg_q_next     = is_signed & (ex_reg1[31] ^ ex_reg2[31]);
                        neg_r_next     = is_signed & ex_reg1[31];
                        state_next     = (ex_reg2 == 32'd0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: begin
                    stallreq_o     = 1'b1;
                    dividend_next  = '0;
                    remainder_next = '0;
                    state_next     = END;
                end
                ON: begin
                    stallreq_o = 1'b1;
                    if (!diff[32]) begin
                        remainder_next = diff[31:0];
                        dividend_next  = {dividend_reg[30:0], 1'b1};
                    end else begin
                        remainder_next = rem_shift[31:0];
                        dividend_next  = {dividend_reg[30:0], 1'b0};
                    end
                    cnt_next = cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        state_next = END;
                    end
                end
                END: begin
                    whilo_o    = 1'b1;
                    lo_o       = neg_q_reg ? (~dividend_reg + 32'd1) : dividend_reg;
                    hi_o       = neg_r_reg ? (~remainder_reg + 32'd1) : remainder_reg;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end
`else
    logic unused_ok;

    assign unused_ok  = &{1'b0, clk, rst, annul_i, ex_is_in_delayslot};
    assign whilo_o    = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
    assign stallreq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU result classes, link path, and (when EX_DIV_EN is
// defined) divider latency, signs, divide-by-zero, annul and reset aborts.
module tb_ex_stage;

    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_SLT  = 8'b00101010;
    localparam logic [7:0] OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;
    localparam logic [7:0] OP_JAL  = 8'b01010000;
    localparam logic [7:0] OP_NOP  = 8'b00000000;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_JB    = 3'b110;

    logic        clk;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_link_address;
    logic        ex_is_in_delayslot;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int compared   = 0;
    int mismatched = 0;

    ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .ex_aluop          (ex_aluop),
        .ex_alusel         (ex_alusel),
        .ex_reg1           (ex_reg1),
        .ex_reg2           (ex_reg2),
        .ex_wd             (ex_wd),
        .ex_wreg           (ex_wreg),
        .ex_link_address   (ex_link_address),
        .ex_is_in_delayslot(ex_is_in_delayslot),
        .annul_i           (annul_i),
        .wd_o              (wd_o),
        .wreg_o            (wreg_o),
        .wdata_o           (wdata_o),
        .whilo_o           (whilo_o),
        .hi_o              (hi_o),
        .lo_o              (lo_o),
        .stallreq_o        (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                       input logic [31:0] exp);
        @(posedge clk); #1;
        ex_aluop = op; ex_alusel = sel; ex_reg1 = a; ex_reg2 = b;
        ex_wd = wd; ex_wreg = 1'b1;
        @(negedge clk);
        $display("alu %s: a=%h b=%h wdata=%h wd=%0d", tag, a, b, wdata_o, wd_o);
        chk({tag, "_wdata"}, wdata_o, exp);
        chk({tag, "_wd"}, {27'b0, wd_o}, {27'b0, wd});
        chk({tag, "_wreg"}, {31'b0, wreg_o}, 32'd1);
        chk({tag, "_stall"}, {31'b0, stallreq_o}, 32'd0);
    endtask

`ifdef EX_DIV_EN
    // Presents a divide one cycle after the current one, scrambles the operands in
    // cycle 1, and waits (bounded) for whilo_o.
    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_lat);
        int lat, stalls;
        bit seen;
        lat = -1; stalls = 0; seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; annul_i = 1'b0;
        ex_aluop = op; ex_alusel = SEL_NOP; ex_reg1 = a; ex_reg2 = b;
        ex_wd = 5'd3; ex_wreg = 1'b1;
        @(negedge clk);
        chk({tag, "_wreg"}, {31'b0, wreg_o}, 32'd0);
        if (stallreq_o) stalls++;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                ex_reg1 = ~a;
                ex_reg2 = b + 32'd3;
            end
            @(negedge clk);
            if (whilo_o) begin
                seen = 1'b1;
                lat = c;
                chk({tag, "_lo"}, lo_o, exp_lo);
                chk({tag, "_hi"}, hi_o, exp_hi);
                chk({tag, "_stall_end"}, {31'b0, stallreq_o}, 32'd0);
            end else if (stallreq_o) begin
                stalls++;
            end
        end
        $display("div %s: a=%h b=%h latency=%0d lo=%h hi=%h", tag, a, b, lat, lo_o, hi_o);
        chk({tag, "_done"}, {31'b0, seen}, 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_stall_cycles"}, stalls, exp_lat);
    endtask
`endif

    initial begin
        int whilo_seen;
        rst = 1'b1; annul_i = 1'b0;
        ex_aluop = OP_DIVU; ex_alusel = SEL_NOP; ex_reg1 = 32'd100; ex_reg2 = 32'd7;
        ex_wd = 5'd0; ex_wreg = 1'b0; ex_link_address = 32'h0000_0408;
        ex_is_in_delayslot = 1'b0;
        @(posedge clk); @(negedge clk);
        $display("reset: stall=%b whilo=%b hi=%h lo=%h", stallreq_o, whilo_o, hi_o, lo_o);
        chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
        chk("rst_whilo", {31'b0, whilo_o}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ex_aluop = OP_NOP;
        @(negedge clk);
        chk("post_rst_stall", {31'b0, stallreq_o}, 32'd0);
        chk("post_rst_whilo", {31'b0, whilo_o}, 32'd0);

        alu("or",    OP_OR,   SEL_LOGIC, 32'h0000FF00, 32'h00F0000F, 5'd4,  32'h00F0FF0F);
        alu("and",   OP_AND,  SEL_LOGIC, 32'hF0F01234, 32'h0FF0FF00, 5'd5,  32'h00F01200);
        alu("xor",   OP_XOR,  SEL_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd6,  32'hF0F00F0F);
        alu("nor",   OP_NOR,  SEL_LOGIC, 32'h0000FF00, 32'h00F0000F, 5'd7,  32'hFF0F00F0);
        alu("addu",  OP_ADDU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'h00000001);
        alu("subu",  OP_SUBU, SEL_ARITH, 32'h00000003, 32'h00000005, 5'd9,  32'hFFFFFFFE);
        alu("slt",   OP_SLT,  SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 5'd10, 32'h00000001);
        alu("sltu",  OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 5'd11, 32'h00000000);
        alu("sll",   OP_SLL,  SEL_SHIFT, 32'h00000004, 32'h0000000F, 5'd12, 32'h000000F0);
        alu("sll32", OP_SLL,  SEL_SHIFT, 32'h00000020, 32'h12345678, 5'd13, 32'h12345678);
        alu("srl",   OP_SRL,  SEL_SHIFT, 32'h00000004, 32'h80000000, 5'd14, 32'h08000000);
        alu("sra",   OP_SRA,  SEL_SHIFT, 32'h00000004, 32'h80000000, 5'd15, 32'hF8000000);
        alu("sra31", OP_SRA,  SEL_SHIFT, 32'hFFFFFFFF, 32'h80000000, 5'd16, 32'hFFFFFFFF);
        alu("jal",   OP_JAL,  SEL_JB,    32'h00000000, 32'h00000000, 5'd31, 32'h00000408);
        alu("nop",   OP_OR,   SEL_NOP,   32'h0000FF00, 32'h00F0000F, 5'd1,  32'h00000000);
        alu("unk",   8'hFF,   SEL_LOGIC, 32'h0000FF00, 32'h00F0000F, 5'd2,  32'h00000000);

`ifdef EX_DIV_EN
        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        run_div("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33);
        run_div("div_5_0", OP_DIV, 32'd5, 32'd0, 32'd0, 32'd0, 2);
        @(posedge clk); #1;
        ex_aluop = OP_NOP;
        @(negedge clk);
        chk("idle_whilo", {31'b0, whilo_o}, 32'd0);
        chk("idle_lo", lo_o, 32'd0);

        // Annul at cycle 10 of a DIVU; FSM must be IDLE in cycle 11.
        @(posedge clk); #1;
        ex_aluop = OP_DIVU; ex_reg1 = 32'd100; ex_reg2 = 32'd7;
        whilo_seen = 0;
        @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 10) annul_i = 1'b1;
            @(negedge clk);
            if (whilo_o) whilo_seen++;
        end
        $display("annul: stall=%b whilo=%b", stallreq_o, whilo_o);
        chk("annul_stall", {31'b0, stallreq_o}, 32'd0);
        chk("annul_whilo_seen", whilo_seen, 0);
        run_div("after_annul", OP_DIVU, 32'd5, 32'd0, 32'd0, 32'd0, 2);

        // Reset at cycle 5 of a DIVU aborts the same way.
        @(posedge clk); #1;
        ex_aluop = OP_DIVU; ex_reg1 = 32'd100; ex_reg2 = 32'd7;
        whilo_seen = 0;
        @(negedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 5) rst = 1'b1;
            @(negedge clk);
            if (whilo_o) whilo_seen++;
        end
        $display("rst abort: stall=%b whilo=%b hi=%h lo=%h", stallreq_o, whilo_o, hi_o, lo_o);
        chk("rstab_stall", {31'b0, stallreq_o}, 32'd0);
        chk("rstab_whilo_seen", whilo_seen, 0);
        chk("rstab_hi", hi_o, 32'd0);
        run_div("after_rst", OP_DIVU, 32'd5, 32'd0, 32'd0, 32'd0, 2);
`else
        // Without the divider, DIV behaves as a NOP that never stalls.
        @(posedge clk); #1;
        ex_aluop = OP_DIV; ex_alusel = SEL_NOP; ex_reg1 = 32'd100; ex_reg2 = 32'd7;
        ex_wd = 5'd3; ex_wreg = 1'b1;
        whilo_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o || stallreq_o) whilo_seen++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        $display("div disabled: wreg=%b wdata=%h active_cycles=%0d", wreg_o, wdata_o, whilo_seen);
        chk("nodiv_active", whilo_seen, 0);
        chk("nodiv_wreg", {31'b0, wreg_o}, 32'd0);
        chk("nodiv_wdata", wdata_o, 32'd0);
        chk("nodiv_hi", hi_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
